// File: rtl/pgm_pkg.sv
// Shared constants and types for the PGM ROM download path.
package pgm_pkg;

  // ioctl_index values of the three ROM images
  localparam logic [7:0] IDX_BIOS = 8'd0;
  localparam logic [7:0] IDX_PROM = 8'd1;
  localparam logic [7:0] IDX_GFX  = 8'd2;

  // Loader sequencing
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  // Address of one 64-bit DDRAM line
  typedef logic [28:0] line_addr_t;

endpackage

// File: rtl/pgm_rom_loader_if.sv
// DDRAM write-side bus between the ROM loader (master) and the arbiter (slave).
// Handshake: the master raises ddram_we with ddram_addr/din/be and holds all
// four unchanged until a cycle in which ddram_busy is 0; that cycle is the
// transfer. ddram_busy may change at any time, ddram_we never drops untaken.
interface pgm_rom_loader_if;
  import pgm_pkg::*;

  logic        ddram_we;
  line_addr_t  ddram_addr;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic        ddram_busy;

  modport master (output ddram_we, ddram_addr, ddram_din, ddram_be, input ddram_busy);
  modport slave  (input ddram_we, ddram_addr, ddram_din, ddram_be, output ddram_busy);

endinterface

// File: rtl/pgm_line_packer.sv
// Assembly register: merges 16-bit words into one 64-bit line and decides
// when that line (or a just-completed one) leaves for the pending register.
module pgm_line_packer
  import pgm_pkg::*;
#(
  parameter bit SWAP_BYTES = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        src_v_i,       // a word is offered this cycle
  input  logic [25:0] src_waddr_i,   // word address (byte address >> 1)
  input  logic [15:0] src_data_i,
  input  logic        pend_free_i,   // pending register can take a line now
  input  logic        force_i,       // flush whatever is buffered
  output logic        take_o,        // offered word consumed
  output logic        flush_v_o,
  output logic [23:0] flush_line_o,
  output logic [63:0] flush_data_o,
  output logic [7:0]  flush_be_o,
  output logic        asm_valid_o
);

  logic        asm_v_q, asm_v_d;
  logic        asm_cmpl_q, asm_cmpl_d;  // lane 3 written but flush was blocked
  logic [23:0] asm_line_q, asm_line_d;
  logic [63:0] asm_data_q, asm_data_d;
  logic [7:0]  asm_be_q, asm_be_d;

  logic [23:0] w_line;
  logic [1:0]  w_lane;
  logic [15:0] w_word;
  logic [63:0] lane_data, lane_mask, merged_data;
  logic [7:0]  lane_be, merged_be;
  logic        mism;

  assign w_line    = src_waddr_i[25:2];
  assign w_lane    = src_waddr_i[1:0];
  assign w_word    = SWAP_BYTES ? {src_data_i[7:0], src_data_i[15:8]} : src_data_i;
  assign lane_data = {48'd0, w_word} << {w_lane, 4'd0};
  assign lane_mask = {48'd0, 16'hFFFF} << {w_lane, 4'd0};
  assign lane_be   = 8'h03 << {w_lane, 1'b0};
  // A word that cannot join the buffered line forces that line out first
  assign mism      = asm_v_q & (asm_cmpl_q | (w_line != asm_line_q));
  assign merged_data = ((asm_v_q ? asm_data_q : 64'd0) & ~lane_mask) | lane_data;
  assign merged_be   = (asm_v_q ? asm_be_q : 8'd0) | lane_be;
  assign asm_valid_o = asm_v_q;

  // Merge / flush decision for the offered word
  always_comb begin
    take_o       = 1'b0;
    flush_v_o    = 1'b0;
    flush_line_o = asm_line_q;
    flush_data_o = asm_data_q;
    flush_be_o   = asm_be_q;
    asm_v_d      = asm_v_q;
    asm_cmpl_d   = asm_cmpl_q;
    asm_line_d   = asm_line_q;
    asm_data_d   = asm_data_q;
    asm_be_d     = asm_be_q;
    if (src_v_i) begin
      if (mism) begin
        if (pend_free_i) begin
          take_o     = 1'b1;
          flush_v_o  = 1'b1;
          asm_v_d    = 1'b1;
          asm_cmpl_d = (w_lane == 2'd3);
          asm_line_d = w_line;
          asm_data_d = lane_data;
          asm_be_d   = lane_be;
        end
      end else if (w_lane == 2'd3) begin
        if (pend_free_i) begin
          take_o       = 1'b1;
          flush_v_o    = 1'b1;
          flush_line_o = w_line;
          flush_data_o = merged_data;
          flush_be_o   = merged_be;
          asm_v_d      = 1'b0;
          asm_cmpl_d   = 1'b0;
          asm_data_d   = 64'd0;
          asm_be_d     = 8'd0;
        end
      end else begin
        take_o     = 1'b1;
        asm_v_d    = 1'b1;
        asm_line_d = w_line;
        asm_data_d = merged_data;
        asm_be_d   = merged_be;
      end
    end else if (asm_v_q && (asm_cmpl_q || force_i) && pend_free_i) begin
      flush_v_o  = 1'b1;
      asm_v_d    = 1'b0;
      asm_cmpl_d = 1'b0;
      asm_data_d = 64'd0;
      asm_be_d   = 8'd0;
    end
  end

  // Assembly register update
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      asm_v_q    <= 1'b0;
      asm_cmpl_q <= 1'b0;
      asm_line_q <= 24'd0;
      asm_data_q <= 64'd0;
      asm_be_q   <= 8'd0;
    end else begin
      asm_v_q    <= asm_v_d;
      asm_cmpl_q <= asm_cmpl_d;
      asm_line_q <= asm_line_d;
      asm_data_q <= asm_data_d;
      asm_be_q   <= asm_be_d;
    end
  end

endmodule

// File: rtl/pgm_rom_loader.sv
// MiSTer ioctl download -> PGM DDRAM line writer: packs words, relocates by
// image index, throttles the HPS, drains the tail and pulses dl_done.
module pgm_rom_loader
  import pgm_pkg::*;
#(
  parameter line_addr_t BIOS_BASE  = 29'h0000000,
  parameter line_addr_t PROM_BASE  = 29'h0020000,
  parameter line_addr_t GFX_BASE   = 29'h0100000,
  parameter bit         SWAP_BYTES = 1'b1
) (
  input  logic              fixed_50m_clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [26:0]       ioctl_addr,
  input  logic [15:0]       ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  pgm_rom_loader_if.master  ddram,
  output logic              dl_done,
  output logic              dl_err,
  output loader_state_t     dbg_state_o
);

  loader_state_t state_q, state_d;
  line_addr_t    base_q, base_d;
  logic          supp_q, supp_d;     // unmapped image: drop every word
  logic          err_q, err_d;
  logic          skid_v_q, skid_v_d;
  logic [25:0]   skid_waddr_q, skid_waddr_d;
  logic [15:0]   skid_data_q, skid_data_d;
  logic          pend_v_q, pend_v_d;
  line_addr_t    pend_addr_q, pend_addr_d;
  logic [63:0]   pend_data_q, pend_data_d;
  logic [7:0]    pend_be_q, pend_be_d;

  logic          in_v, src_v, pend_acc, pend_free, take, flush_v, asm_valid;
  logic [25:0]   src_waddr;
  logic [15:0]   src_data;
  logic [23:0]   flush_line;
  logic [63:0]   flush_data;
  logic [7:0]    flush_be;
  logic          addr_lsb_unused;

  assign addr_lsb_unused = ioctl_addr[0];
  assign in_v      = (state_q == LOAD) & ioctl_wr & ~supp_q;
  // The skid word is older than anything arriving now, so it goes first
  assign src_v     = skid_v_q | in_v;
  assign src_waddr = skid_v_q ? skid_waddr_q : ioctl_addr[26:1];
  assign src_data  = skid_v_q ? skid_data_q : ioctl_dout;
  assign pend_acc  = pend_v_q & ~ddram.ddram_busy;
  assign pend_free = ~pend_v_q | ~ddram.ddram_busy;

  pgm_line_packer #(.SWAP_BYTES(SWAP_BYTES)) u_packer (
    .clk_i        (fixed_50m_clk),
    .rst_n_i      (reset_n),
    .src_v_i      (src_v),
    .src_waddr_i  (src_waddr),
    .src_data_i   (src_data),
    .pend_free_i  (pend_free),
    .force_i      (state_q == DRAIN),
    .take_o       (take),
    .flush_v_o    (flush_v),
    .flush_line_o (flush_line),
    .flush_data_o (flush_data),
    .flush_be_o   (flush_be),
    .asm_valid_o  (asm_valid)
  );

  // Skid capture of a word whose flush is blocked, and pending-line loading
  always_comb begin
    skid_v_d     = skid_v_q;
    skid_waddr_d = skid_waddr_q;
    skid_data_d  = skid_data_q;
    if (skid_v_q) begin
      if (take) begin
        skid_v_d     = in_v;
        skid_waddr_d = ioctl_addr[26:1];
        skid_data_d  = ioctl_dout;
      end
    end else if (in_v && !take) begin
      skid_v_d     = 1'b1;
      skid_waddr_d = ioctl_addr[26:1];
      skid_data_d  = ioctl_dout;
    end
    pend_v_d    = pend_v_q & ~pend_acc;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    pend_be_d   = pend_be_q;
    if (flush_v) begin
      pend_v_d    = 1'b1;
      pend_addr_d = base_q + {5'd0, flush_line};
      pend_data_d = flush_data;
      pend_be_d   = flush_be;
    end
  end

  // Download sequencing and image selection
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    supp_d  = supp_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (ioctl_download) begin
        state_d = LOAD;
        supp_d  = 1'b0;
        err_d   = 1'b0;
        case (ioctl_index)
          IDX_BIOS: base_d = BIOS_BASE;
          IDX_PROM: base_d = PROM_BASE;
          IDX_GFX:  base_d = GFX_BASE;
          default: begin
            supp_d = 1'b1;
            err_d  = 1'b1;
          end
        endcase
      end
      LOAD:  if (!ioctl_download) state_d = DRAIN;
      DRAIN: if (!skid_v_q && !asm_valid && (!pend_v_q || pend_acc)) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge fixed_50m_clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      base_q       <= 29'd0;
      supp_q       <= 1'b0;
      err_q        <= 1'b0;
      skid_v_q     <= 1'b0;
      skid_waddr_q <= 26'd0;
      skid_data_q  <= 16'd0;
      pend_v_q     <= 1'b0;
      pend_addr_q  <= 29'd0;
      pend_data_q  <= 64'd0;
      pend_be_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      supp_q       <= supp_d;
      err_q        <= err_d;
      skid_v_q     <= skid_v_d;
      skid_waddr_q <= skid_waddr_d;
      skid_data_q  <= skid_data_d;
      pend_v_q     <= pend_v_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      pend_be_q    <= pend_be_d;
    end
  end

  // Hold the HPS whenever the next word might need a flush that cannot happen
  assign ioctl_wait       = skid_v_q | (pend_v_q & asm_valid);
  assign ddram.ddram_we   = pend_v_q;
  assign ddram.ddram_addr = pend_addr_q;
  assign ddram.ddram_din  = pend_data_q;
  assign ddram.ddram_be   = pend_be_q;
  assign dl_done          = (state_q == DONE);
  assign dl_err           = err_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_pgm_rom_loader.sv
// Bench for pgm_rom_loader: a line-packing reference model fills an expected
// queue as words are driven; a monitor pops and compares accepted writes.
module tb_pgm_rom_loader;
  import pgm_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [26:0]   ioctl_addr = '0;
  logic [15:0]   ioctl_dout = '0;
  logic [7:0]    ioctl_index = '0;
  logic          ioctl_wait, dl_done, dl_err;
  loader_state_t dbg_state;

  pgm_rom_loader_if ddr ();

  pgm_rom_loader dut (
    .fixed_50m_clk  (clk),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .ddram          (ddr),
    .dl_done        (dl_done),
    .dl_err         (dl_err),
    .dbg_state_o    (dbg_state)
  );

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard: {addr[28:0], be[7:0], data[63:0]}
  logic [100:0] exp_q[$];

  // reference model of the line being assembled
  logic        m_valid = 1'b0;
  logic        m_supp = 1'b0;
  logic [23:0] m_line;
  logic [63:0] m_data;
  logic [7:0]  m_be;
  logic [28:0] m_base;

  task automatic model_push();
    exp_q.push_back({m_base + {5'd0, m_line}, m_be, m_data});
    m_valid = 1'b0;
  endtask

  task automatic model_word(input logic [26:0] a, input logic [15:0] d);
    logic [23:0] ln;
    int k;
    if (m_supp) return;
    ln = a[26:3];
    k = int'(a[2:1]);
    if (m_valid && ln != m_line) model_push();
    if (!m_valid) begin
      m_line = ln; m_data = '0; m_be = '0; m_valid = 1'b1;
    end
    m_data[k*16 +: 16] = {d[7:0], d[15:8]};
    m_be[k*2 +: 2] = 2'b11;
    if (k == 3) model_push();
  endtask

  // monitor
  int          wr_cnt = 0, done_cnt = 0, done_cyc = 0, last_acc_cyc = 0;
  logic [28:0] last_addr;
  logic [63:0] last_din;
  logic [7:0]  last_be;
  logic        wait_seen = 1'b0;
  logic        stall_q = 1'b0, done_prev = 1'b0;
  logic [28:0] s_addr;
  logic [63:0] s_din;
  logic [7:0]  s_be;

  always @(negedge clk) begin
    if (!reset_n) begin
      stall_q = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (stall_q) begin
        check_eq("stall_we", ddr.ddram_we, 1'b1);
        check_eq("stall_addr", ddr.ddram_addr, s_addr);
        check_eq("stall_din", ddr.ddram_din, s_din);
        check_eq("stall_be", ddr.ddram_be, s_be);
      end
      if (ddr.ddram_we && !ddr.ddram_busy) begin
        logic [100:0] e;
        logic [63:0] mask;
        wr_cnt++;
        last_acc_cyc = cyc;
        last_addr = ddr.ddram_addr; last_din = ddr.ddram_din; last_be = ddr.ddram_be;
        check_eq("wr_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          for (int b = 0; b < 8; b++) mask[b*8 +: 8] = {8{e[64+b]}};
          check_eq("wr_addr", ddr.ddram_addr, e[100:72]);
          check_eq("wr_be", ddr.ddram_be, e[71:64]);
          check_eq("wr_data", ddr.ddram_din & mask, e[63:0] & mask);
        end
      end
      if (ioctl_wait) wait_seen = 1'b1;
      if (dl_done) begin
        check_eq("done_width", done_prev, 1'b0);
        done_cnt++;
        done_cyc = cyc;
      end
      done_prev = dl_done;
      stall_q = ddr.ddram_we & ddr.ddram_busy;
      s_addr = ddr.ddram_addr; s_din = ddr.ddram_din; s_be = ddr.ddram_be;
    end
  end

  // driver tasks (all start and end just after a rising edge)
  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    m_valid = 1'b0;
    m_supp = (idx > 8'd2);
    case (idx)
      8'd0: m_base = 29'h0000000;
      8'd1: m_base = 29'h0020000;
      default: m_base = 29'h0100000;
    endcase
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [26:0] a, input logic [15:0] d);
    int n = 0;
    while (ioctl_wait && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check_eq("wait_bound", n, 0);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    model_word(a, d);
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic end_dl();
    int start_cnt = done_cnt;
    int n = 0;
    ioctl_download = 1'b0;
    if (m_valid && !m_supp) model_push();
    while (done_cnt == start_cnt && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("done_seen", done_cnt - start_cnt, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    ddr.ddram_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_we", ddr.ddram_we, 1'b0);
    check_eq("rst_wait", ioctl_wait, 1'b0);
    check_eq("rst_done", dl_done, 1'b0);
    check_eq("rst_err", dl_err, 1'b0);
    check_eq("rst_state", dbg_state, IDLE);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // full aligned BIOS line
    w0 = wr_cnt;
    start_dl(8'd0);
    send_word(27'h0, 16'h1122);
    send_word(27'h2, 16'h3344);
    send_word(27'h4, 16'h5566);
    send_word(27'h6, 16'h7788);
    end_dl();
    check_eq("t1_count", wr_cnt - w0, 1);
    check_eq("t1_addr", last_addr, 29'h0000000);
    check_eq("t1_be", last_be, 8'hFF);
    check_eq("t1_din", last_din, 64'h8877665544332211);

    // single P-ROM word flushed by the end of download
    w0 = wr_cnt;
    start_dl(8'd1);
    send_word(27'h000A, 16'hABCD);
    end_dl();
    check_eq("t2_count", wr_cnt - w0, 1);
    check_eq("t2_addr", last_addr, 29'h0020001);
    check_eq("t2_be", last_be, 8'h0C);
    check_eq("t2_din", last_din[31:16], 16'hCDAB);
    check_eq("t2_done_lat", done_cyc - last_acc_cyc, 1);

    // GFX: line change forces a partial flush
    w0 = wr_cnt;
    start_dl(8'd2);
    send_word(27'h10, 16'h0102);
    send_word(27'h40, 16'h0304);
    end_dl();
    check_eq("t3_count", wr_cnt - w0, 2);
    check_eq("t3_addr", last_addr, 29'h0100008);
    check_eq("t3_be", last_be, 8'h03);

    // 12-word burst with DDRAM stalled for 20 cycles
    w0 = wr_cnt;
    wait_seen = 1'b0;
    ddr.ddram_busy = 1'b1;
    start_dl(8'd2);
    fork
      for (int i = 0; i < 12; i++) send_word(27'h200 + 27'(2*i), 16'($urandom_range(0, 16'hFFFF)));
      begin
        repeat (20) @(posedge clk);
        #1 ddr.ddram_busy = 1'b0;
      end
    join
    end_dl();
    check_eq("t4_count", wr_cnt - w0, 3);
    check_eq("t4_wait", wait_seen, 1'b1);

    // lone lane-3 words while stalled: second one goes through the skid
    w0 = wr_cnt;
    wait_seen = 1'b0;
    ddr.ddram_busy = 1'b1;
    start_dl(8'd0);
    send_word(27'h06, 16'($urandom_range(0, 16'hFFFF)));
    send_word(27'h0E, 16'($urandom_range(0, 16'hFFFF)));
    repeat (5) @(posedge clk);
    #1 ddr.ddram_busy = 1'b0;
    end_dl();
    check_eq("t4b_count", wr_cnt - w0, 2);
    check_eq("t4b_wait", wait_seen, 1'b1);

    // unmapped index: no writes, sticky error, done still pulses
    w0 = wr_cnt;
    start_dl(8'd5);
    for (int i = 0; i < 8; i++) send_word(27'(2*i), 16'($urandom_range(0, 16'hFFFF)));
    end_dl();
    check_eq("t5_count", wr_cnt - w0, 0);
    check_eq("t5_err", dl_err, 1'b1);
    start_dl(8'd1);
    check_eq("t5_err_clr", dl_err, 1'b0);
    send_word(27'h20, 16'h5A5A);
    end_dl();

    // reset with two lanes buffered
    w0 = wr_cnt;
    start_dl(8'd0);
    send_word(27'h100, 16'h1111);
    send_word(27'h102, 16'h2222);
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    m_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_eq("t6_we", ddr.ddram_we, 1'b0);
    check_eq("t6_addr", ddr.ddram_addr, 29'd0);
    check_eq("t6_be", ddr.ddram_be, 8'd0);
    check_eq("t6_wait", ioctl_wait, 1'b0);
    check_eq("t6_done", dl_done, 1'b0);
    check_eq("t6_state", dbg_state, IDLE);
    repeat (10) @(posedge clk);
    #1;
    check_eq("t6_count", wr_cnt - w0, 0);
    check_eq("exp_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
